dp_sram_fifo_ctrl: RTL and testbench
====================================

// Module: dp_sram_fifo_ctrl
// PURPOSE
//  Pointer/flag controller that sits directly upstream of the dual-port SRAM (din/wen/ren/addrw/addrr/dout, 8x16).
//  Converts a push/pop stream interface into SRAM write/read strobes and addresses, so the SRAM operates as a
//  16-entry synchronous FIFO. Tracks occupancy and full/empty/almost flags, and reports pop-data validity
//  against the SRAM's one-cycle registered read latency. Flags overflow/underflow attempts as sticky errors.
// PARAMETERS
//  DATA_W     8   data width; must match SRAM din/dout
//  ADDR_W     4   SRAM address width; DEPTH = 2**ADDR_W = 16
//  AF_THRESH  12  almost_full asserted when count >= AF_THRESH
//  AE_THRESH  2   almost_empty asserted when count <= AE_THRESH
// PORTS
//  clk           in   1         single clock; all state updates on posedge
//  rst           in   1         synchronous, active-high reset
//  push          in   1         request to write push_data this cycle
//  push_data     in   DATA_W    data to enqueue
//  pop           in   1         request to read oldest entry this cycle
//  pop_data      out  DATA_W    = sram_dout (combinational pass-through); meaningful only when pop_valid=1
//  pop_valid     out  1         registered; high the cycle after an accepted pop
//  full          out  1         count == DEPTH
//  empty         out  1         count == 0
//  almost_full   out  1         count >= AF_THRESH
//  almost_empty  out  1         count <= AE_THRESH
//  count         out  ADDR_W+1  occupancy, 0..DEPTH
//  overflow      out  1         sticky: push attempted while full
//  underflow     out  1         sticky: pop attempted while empty
//  sram_din      out  DATA_W    = push_data
//  sram_wen      out  1         = push & ~full (combinational)
//  sram_addrw    out  ADDR_W    = wr_ptr[ADDR_W-1:0]
//  sram_ren      out  1         = pop & ~empty (combinational)
//  sram_addrr    out  ADDR_W    = rd_ptr[ADDR_W-1:0]
//  sram_dout     in   DATA_W    SRAM read data, valid one clk after sram_ren
// BEHAVIOUR
//  - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0, pop_valid=0, overflow=underflow=0; hence empty=1, full=0,
//    almost_empty=1, almost_full=0, sram_wen=sram_ren=0. rst overrides any push/pop in the same cycle; a transfer
//    in flight is discarded (pop_valid=0 next cycle).
//  - Pointers are ADDR_W+1 bits; low ADDR_W bits address SRAM, MSB is wrap bit. Increment wraps 15->0 naturally.
//  - Accept rules: wr_acc = push & ~full; rd_acc = pop & ~empty. Flags evaluated from registered count only.
//  - Full: push rejected even if pop in same cycle (no same-address read/write); pop still accepted.
//  - Empty: pop rejected even if push in same cycle (no write-through); push still accepted.
//  - Per posedge: wr_ptr += wr_acc; rd_ptr += rd_acc; count += wr_acc - rd_acc (both -> count unchanged).
//  - Read latency: sram_ren/addrr presented in cycle N, SRAM registers dout at posedge N; pop_valid=1 in cycle N+1,
//    pop_data valid then. Back-to-back pops give one word per cycle.
//  - Write: sram_wen/addrw/din presented in cycle N, written at posedge N; entry poppable from cycle N+1.
//  - overflow set when push & full; underflow set when pop & empty; both held until rst.
//  - count never exceeds DEPTH nor goes below 0; rejected requests change no state other than error flags.
// TESTING
//  1 Reset: assert rst 2 cycles with push=pop=1 -> count=0, empty=1, sram_wen=sram_ren=0, pop_valid=0, errors=0.
//  2 Fill: push 16 words 8'd1..8'd16 -> addrw 0..15, full=1 after 16th, almost_full from count=12; 17th push
//    -> sram_wen=0, count stays 16, overflow=1.
//  3 Drain: pop 16 times back-to-back -> pop_valid each next cycle, pop_data 1..16 in order, empty=1;
//    extra pop -> sram_ren=0, underflow=1, pop_valid=0.
//  4 Wrap: push 10, pop 10, push 10 -> addrw wraps 15->0 at 7th of 2nd batch; pop returns 2nd batch in order.
//  5 Simultaneous: count=5, push+pop same cycle -> count stays 5; at full push+pop -> only pop accepted, count=15;
//    at empty push+pop -> only push accepted, count=1, pop_valid=0.
//  6 Mid-op reset: pop accepted in cycle N, rst in cycle N -> pop_valid=0 at N+1, count=0, pointers 0.

Source files
------------

// File: rtl/dp_sram_fifo_ctrl.sv
// Push/pop to dual-port SRAM controller: turns the SRAM into a 16-entry synchronous FIFO
// with occupancy, threshold flags, registered pop validity and sticky overflow/underflow.
module dp_sram_fifo_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned AF_THRESH = 12,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic [DATA_W-1:0] sram_din,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addrw,
  output logic              sram_ren,
  output logic [ADDR_W-1:0] sram_addrr,
  input  logic [DATA_W-1:0] sram_dout
);

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            pop_valid_q, pop_valid_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic            wr_acc, rd_acc;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  // Strobes are masked during reset so no SRAM access escapes a cycle whose state is discarded.
  assign wr_acc = push & ~full & ~rst;
  assign rd_acc = pop & ~empty & ~rst;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pop_valid_d = rd_acc;
    overflow_d  = overflow_q | (push & full);
    underflow_d = underflow_q | (pop & empty);
    if (wr_acc) wr_ptr_d = wr_ptr_q + ONE_C;
    if (rd_acc) rd_ptr_d = rd_ptr_q + ONE_C;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign count      = count_q;
  assign pop_valid  = pop_valid_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign pop_data   = sram_dout;
  assign sram_din   = push_data;
  assign sram_wen   = wr_acc;
  assign sram_ren   = rd_acc;
  assign sram_addrw = wr_ptr_q[ADDR_W-1:0];
  assign sram_addrr = rd_ptr_q[ADDR_W-1:0];

endmodule

// File: tb/tb_dp_sram_fifo_ctrl.sv
// Bench for dp_sram_fifo_ctrl: behavioural SRAM, queue-based FIFO model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dp_sram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst, push, pop;
  logic [7:0] push_data, pop_data, sram_din, sram_dout;
  logic       pop_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  logic       sram_wen, sram_ren;
  logic [3:0] sram_addrw, sram_addrr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dp_sram_fifo_ctrl #(.DATA_W(8), .ADDR_W(4), .AF_THRESH(12), .AE_THRESH(2)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .sram_din(sram_din),
    .sram_wen(sram_wen), .sram_addrw(sram_addrw), .sram_ren(sram_ren),
    .sram_addrr(sram_addrr), .sram_dout(sram_dout)
  );

  // SRAM with one-cycle registered read
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (sram_wen) mem[sram_addrw] <= sram_din;
    if (sram_ren) sram_dout <= mem[sram_addrr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of stored words plus wrap-around pointer integers
  logic [7:0] mq[$];
  int         wptr = 0, rptr = 0;
  bit         m_ovf = 0, m_udf = 0, m_pv = 0, started = 0;
  logic [7:0] m_pd = '0;

  always @(posedge clk) begin
    int n;
    n = mq.size();
    if (rst) begin
      mq.delete();
      wptr = 0; rptr = 0; m_ovf = 0; m_udf = 0; m_pv = 0;
    end else begin
      m_pv = pop && n > 0;
      if (pop && n > 0) begin
        m_pd = mq.pop_front();
        rptr = (rptr + 1) % 32;
      end
      if (push && n < 16) begin
        mq.push_back(push_data);
        wptr = (wptr + 1) % 32;
      end
      if (push && n == 16) m_ovf = 1;
      if (pop && n == 0) m_udf = 1;
    end
    started = 1;
  end

  always @(negedge clk) begin
    int n;
    if (started) begin
      n = mq.size();
      chk("count", 32'(count), n);
      chk("full", 32'(full), 32'(n == 16));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("almost_full", 32'(almost_full), 32'(n >= 12));
      chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
      chk("sram_wen", 32'(sram_wen), 32'(push && !rst && n < 16));
      chk("sram_ren", 32'(sram_ren), 32'(pop && !rst && n > 0));
      chk("sram_addrw", 32'(sram_addrw), wptr % 16);
      chk("sram_addrr", 32'(sram_addrr), rptr % 16);
      chk("sram_din", 32'(sram_din), 32'(push_data));
      chk("pop_valid", 32'(pop_valid), 32'(m_pv));
      if (m_pv) chk("pop_data", 32'(pop_data), 32'(m_pd));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_udf));
    end
  end

  task automatic cyc(input bit p, input bit q, input logic [7:0] d, input bit r);
    push = p; pop = q; push_data = d; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 0);
  endtask

  initial begin
    int pp, pq;
    push = 0; pop = 0; push_data = '0; rst = 1;

    // Reset with push and pop held high
    cyc(1, 1, 8'hAA, 1);
    cyc(1, 1, 8'hAA, 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_wen", 32'(sram_wen), 0);
    chk("rst_ren", 32'(sram_ren), 0);
    chk("rst_pop_valid", 32'(pop_valid), 0);
    chk("rst_errors", 32'({overflow, underflow}), 0);
    cyc(0, 0, 8'h00, 0);

    // Fill with 1..16, then one extra push
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0, 8'(i), 0);
      if (i == 11) chk("af_below", 32'(almost_full), 0);
      if (i == 12) chk("af_at12", 32'(almost_full), 1);
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    push = 1; push_data = 8'h77; #1;
    chk("ovf_wen", 32'(sram_wen), 0);
    cyc(1, 0, 8'h77, 0);
    chk("ovf_count", 32'(count), 16);
    chk("ovf_flag", 32'(overflow), 1);

    // Drain back-to-back
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 1, 8'h00, 0);
      chk("drain_valid", 32'(pop_valid), 1);
      chk("drain_data", 32'(pop_data), i);
    end
    chk("drain_empty", 32'(empty), 1);
    pop = 1; #1;
    chk("udf_ren", 32'(sram_ren), 0);
    cyc(0, 1, 8'h00, 0);
    chk("udf_flag", 32'(underflow), 1);
    chk("udf_valid", 32'(pop_valid), 0);
    do_reset();

    // Wrap: push 10, pop 10, push 10 (7th write lands at address 0), pop 10
    for (int i = 0; i < 10; i++) cyc(1, 0, 8'(8'h20 + i), 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 8'h00, 0);
    for (int i = 0; i < 10; i++) begin
      push = 1; pop = 0; push_data = 8'(8'h40 + i); #1;
      if (i == 5) chk("wrap_addr15", 32'(sram_addrw), 15);
      if (i == 6) chk("wrap_addr0", 32'(sram_addrw), 0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 8'h00, 0);
      chk("wrap_data", 32'(pop_data), 8'h40 + i);
    end
    do_reset();

    // Simultaneous push+pop at mid, full and empty occupancy
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'(i), 0);
    cyc(1, 1, 8'h55, 0);
    chk("sim_mid_count", 32'(count), 5);
    for (int i = 0; i < 11; i++) cyc(1, 0, 8'(8'h60 + i), 0);
    chk("sim_full_pre", 32'(count), 16);
    cyc(1, 1, 8'h99, 0);
    chk("sim_full_count", 32'(count), 15);
    do_reset();
    cyc(1, 1, 8'h33, 0);
    chk("sim_empty_count", 32'(count), 1);
    chk("sim_empty_valid", 32'(pop_valid), 0);
    do_reset();

    // Reset in the same cycle as an accepted-looking pop
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'(i), 0);
    cyc(0, 1, 8'h00, 1);
    push = 0; pop = 0; rst = 0; #1;
    chk("midrst_valid", 32'(pop_valid), 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_ptrs", 32'({sram_addrw, sram_addrr}), 0);
    cyc(0, 0, 8'h00, 0);

    // Randomized traffic in blocks with varying push/pop bias
    for (int b = 0; b < 12; b++) begin
      pp = $urandom_range(15, 85);
      pq = 100 - pp + $urandom_range(0, 10);
      for (int c = 0; c < 200; c++)
        cyc($urandom_range(0, 99) < pp, $urandom_range(0, 99) < pq,
            8'($urandom), $urandom_range(0, 299) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
